i2c_target_responder: RTL and testbench

//  Synthesizable I2C target (slave) that answers the i2cmb Wishbone-to-I2C master on one bus.

---
 rtl/i2c_target_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_responder.sv
// i2c_target_responder
//   I2C target that answers one 7-bit address (SLAVE_ADDR) and serves writes
//   and reads against a small byte memory with an auto-incrementing pointer.
//   The first byte of a write sets the pointer. Later write bytes are stored at
//   the pointer. Reads return bytes starting at the current pointer.
//   Optional feature macro: I2C_CLK_STRETCH_EN. When it is defined, SCL is held
//   low for STRETCH_CYCLES clks after every ACK/NACK bit.
//   Handshake: byte_valid_o is a one-clk strobe with no backpressure.
//   byte_data_o and byte_dir_o are meaningful only while byte_valid_o is high.
//   The FSM state is held in 'state' so that checkers can bind to it.
module i2c_target_responder #(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
    parameter int                        MEM_DEPTH      = 8,
    parameter int                        STRETCH_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_oe_o,
    output logic                      scl_oe_o,
    output logic                      byte_valid_o,
    output logic [I2C_DATA_WIDTH-1:0] byte_data_o,
    output logic                      byte_dir_o,
    output logic                      busy_o
);

    localparam int PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int DW    = I2C_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, IGNORE, PTR, WR_DATA, RD_DATA, RD_ACK
    } state_t;

    state_t           state;
    logic [2:0]       scl_sync, sda_sync;  // [0] metastable, [1] synced, [2] history
    logic             scl_now, scl_old, sda_now, sda_old;
    logic             start_det, stop_det, scl_rise, scl_fall, ninth_fall, stretching;
    logic [3:0]       bit_cnt;             // SCL rises seen in the current 9-bit slot
    logic [DW-1:0]    shift_q;
    logic [DW-1:0]    rd_byte;
    logic             rw_q;
    logic             nack_q;
    logic [PTR_W-1:0] ptr;
    logic [DW-1:0]    mem [MEM_DEPTH];

    // Non power-of-two depths, or a zero stretch length, are not supported.
    // This block is a named marker for such a configuration and holds no logic.
    if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 || STRETCH_CYCLES < 1) begin : g_unsupported_cfg
    end

    // Bring the asynchronous bus lines into the clk domain and keep one history flop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_i};
            sda_sync <= {sda_sync[1:0], sda_i};
        end
    end

    assign scl_now   = scl_sync[1];
    assign scl_old   = scl_sync[2];
    assign sda_now   = sda_sync[1];
    assign sda_old   = sda_sync[2];
    assign start_det = scl_now & scl_old & sda_old & ~sda_now;
    assign stop_det  = scl_now & scl_old & ~sda_old & sda_now;
    assign scl_rise  = scl_now & ~scl_old & ~stretching;
    assign scl_fall  = ~scl_now & scl_old;
    // The falling SCL edge that ends our ACK slot, or the master's ACK/NACK slot.
    assign ninth_fall = scl_fall && (bit_cnt == 4'd9) && !start_det && !stop_det &&
                        ((state == ADDR_ACK) || (state == PTR) ||
                         (state == WR_DATA) || (state == RD_ACK));

    // Protocol FSM. Bits are sampled on SCL rise, and SDA changes only on SCL fall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_q      <= '0;
            rd_byte      <= '0;
            rw_q         <= 1'b0;
            nack_q       <= 1'b0;
            ptr          <= '0;
            sda_oe_o     <= 1'b0;
            byte_valid_o <= 1'b0;
            byte_data_o  <= '0;
            byte_dir_o   <= 1'b0;
            busy_o       <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            byte_valid_o <= 1'b0;
            if (start_det) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else if (stop_det) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift_q <= {shift_q[DW-2:0], sda_now};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift_q[I2C_ADDR_WIDTH:1] == SLAVE_ADDR) begin
                                state    <= ADDR_ACK;
                                sda_oe_o <= 1'b1;
                                busy_o   <= 1'b1;
                                rw_q     <= shift_q[0];
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_rise && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd9;
                        end else if (ninth_fall) begin
                            bit_cnt <= '0;
                            if (rw_q) begin
                                state    <= RD_DATA;
                                rd_byte  <= mem[ptr];
                                sda_oe_o <= ~mem[ptr][DW-1];
                                ptr      <= ptr + PTR_W'(1);
                            end else begin
                                state    <= PTR;
                                sda_oe_o <= 1'b0;
                            end
                        end
                    end
                    PTR, WR_DATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift_q <= {shift_q[DW-2:0], sda_now};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_rise && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd9;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            // A full byte has been received. It is committed here, so a
                            // START or STOP before this edge discards the partial byte.
                            sda_oe_o <= 1'b1;
                            if (state == PTR) begin
                                ptr <= shift_q[PTR_W-1:0];
                            end else begin
                                mem[ptr]     <= shift_q;
                                ptr          <= ptr + PTR_W'(1);
                                byte_valid_o <= 1'b1;
                                byte_data_o  <= shift_q;
                                byte_dir_o   <= 1'b0;
                            end
                        end else if (ninth_fall) begin
                            sda_oe_o <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe_o     <= 1'b0;
                            state        <= RD_ACK;
                            byte_valid_o <= 1'b1;
                            byte_data_o  <= rd_byte;
                            byte_dir_o   <= 1'b1;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            sda_oe_o <= ~rd_byte[3'd7 - bit_cnt[2:0]];
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && bit_cnt == 4'd8) begin
                            nack_q  <= sda_now;
                            bit_cnt <= 4'd9;
                        end else if (ninth_fall) begin
                            bit_cnt <= '0;
                            if (nack_q) begin
                                state <= IGNORE;
                            end else begin
                                state    <= RD_DATA;
                                rd_byte  <= mem[ptr];
                                sda_oe_o <= ~mem[ptr][DW-1];
                                ptr      <= ptr + PTR_W'(1);
                            end
                        end
                    end
                    default: ;  // IDLE and IGNORE wait for START or STOP only
                endcase
            end
        end
    end

`ifdef I2C_CLK_STRETCH_EN
    localparam int STR_W = $clog2(STRETCH_CYCLES + 1);
    logic [STR_W-1:0] stretch_cnt;

    // Hold SCL low for STRETCH_CYCLES clks after each ACK/NACK slot. START or STOP releases it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stretch_cnt <= '0;
            scl_oe_o    <= 1'b0;
        end else if (start_det || stop_det) begin
            stretch_cnt <= '0;
            scl_oe_o    <= 1'b0;
        end else if (ninth_fall) begin
            stretch_cnt <= STR_W'(STRETCH_CYCLES - 1);
            scl_oe_o    <= 1'b1;
        end else if (stretch_cnt != '0) begin
            stretch_cnt <= stretch_cnt - 1'b1;
        end else begin
            scl_oe_o <= 1'b0;
        end
    end

    assign stretching = scl_oe_o;
`else
    assign scl_oe_o   = 1'b0;
    assign stretching = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder. A bit-banged I2C master drives open-drain
// SCL/SDA, a byte-memory model supplies the expected values, and a scoreboard
// queue matches every byte_valid_o strobe against the bytes the master moved.
module tb_i2c_target_responder;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n_i;
    logic       scl_drv, sda_drv;
    logic       scl, sda;
    logic       sda_oe_o, scl_oe_o, byte_valid_o, byte_dir_o, busy_o;
    logic [7:0] byte_data_o;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];  // {dir, data}
    logic [7:0] mem_m [8];
    logic [2:0] ptr_m;
    int         sda_oe_cnt = 0;
    int         pulse_cnt = 0;
    int         scl_oe_cnt = 0;
    int         stretch_run = 0;

    // Wired-AND bus: the line is low if either side pulls it low.
    assign scl = scl_drv & ~scl_oe_o;
    assign sda = sda_drv & ~sda_oe_o;

    i2c_target_responder dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .scl_i        (scl),
        .sda_i        (sda),
        .sda_oe_o     (sda_oe_o),
        .scl_oe_o     (scl_oe_o),
        .byte_valid_o (byte_valid_o),
        .byte_data_o  (byte_data_o),
        .byte_dir_o   (byte_dir_o),
        .busy_o       (busy_o)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe pops one expected {dir, data}.
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (sda_oe_o) sda_oe_cnt++;
        if (byte_valid_o) begin
            pulse_cnt++;
            if (exp_q.size() != 0) exp_v = 32'(exp_q.pop_front());
            else exp_v = 'x;
            check("byte_pulse", 32'({byte_dir_o, byte_data_o}), exp_v);
        end
    end

    // Measure the length of each scl_oe_o pulse.
    always @(negedge clk) begin
        if (scl_oe_o) begin
            scl_oe_cnt++;
            stretch_run++;
        end else if (stretch_run != 0) begin
`ifdef I2C_CLK_STRETCH_EN
            check("stretch_len", 32'(stretch_run), 32'd16);
`endif
            stretch_run = 0;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_scl_high();
        int t = 0;
        while (scl !== 1'b1 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        check("scl_high", 32'(scl), 32'd1);
    endtask

    task automatic send_bit(input logic b, output logic s);
        sda_drv = b;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_scl_high();
        wait_clks(Q);
        s = sda;
        wait_clks(Q);
        scl_drv = 1'b0;
        wait_clks(Q);
    endtask

    // Works from an idle bus and as a repeated START from SCL low.
    task automatic i2c_start();
        sda_drv = 1'b1;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_scl_high();
        wait_clks(Q);
        sda_drv = 1'b0;
        wait_clks(Q);
        scl_drv = 1'b0;
        wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_scl_high();
        wait_clks(Q);
        sda_drv = 1'b1;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(ack_bit, s);
    endtask

    task automatic send_addr(input logic [7:0] b, input logic exp_ack);
        logic a;
        write_byte(b, a);
        check("addr_ack", 32'(a), 32'(exp_ack));
    endtask

    task automatic set_ptr(input logic [7:0] p);
        logic a;
        write_byte(p, a);
        check("ptr_ack", 32'(a), 32'd0);
        ptr_m = p[2:0];
    endtask

    task automatic wr_data(input logic [7:0] b);
        logic a;
        exp_q.push_back({1'b0, b});
        write_byte(b, a);
        check("wr_ack", 32'(a), 32'd0);
        mem_m[ptr_m] = b;
        ptr_m++;
    endtask

    task automatic rd_data(input logic ack_bit);
        logic [7:0] e, g;
        e = mem_m[ptr_m];
        exp_q.push_back({1'b1, e});
        ptr_m++;
        read_byte(ack_bit, g);
        check("rd_byte", 32'(g), 32'(e));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
        ptr_m = 3'd0;
    endtask

    task automatic test1_write();
        i2c_start();
        send_addr(8'h44, 1'b0);
        check("busy_after_addr", 32'(busy_o), 32'd1);
        set_ptr(8'h03);
        wr_data(8'hA5);
        wr_data(8'h5A);
        i2c_stop();
        wait_clks(Q);
        check("busy_after_stop", 32'(busy_o), 32'd0);
    endtask

    // Directed sequence.
    initial begin
        int         sda_snap, pulse_snap;
        logic       s;
        logic [7:0] rnd;

        rst_n_i = 1'b0;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        model_reset();
        wait_clks(5);
        @(negedge clk);
        rst_n_i = 1'b1;
        wait_clks(5);
        @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe_o), 32'd0);
        check("rst_scl_oe", 32'(scl_oe_o), 32'd0);
        check("rst_valid", 32'(byte_valid_o), 32'd0);
        check("rst_data", 32'(byte_data_o), 32'd0);
        check("rst_dir", 32'(byte_dir_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);

        // Test 1: pointer 3, write A5 then 5A.
        test1_write();

        // Seed mem[1] so that the current-address read below shows where the pointer is.
        i2c_start();
        send_addr(8'h44, 1'b0);
        set_ptr(8'h01);
        wr_data(8'h3C);
        i2c_stop();

        // Test 2: the write wraps from mem[7] to mem[0] and leaves the pointer at 1.
        i2c_start();
        send_addr(8'h44, 1'b0);
        set_ptr(8'h07);
        wr_data(8'h11);
        wr_data(8'h22);
        i2c_stop();
        i2c_start();
        send_addr(8'h45, 1'b0);
        rd_data(1'b1);  // current address read: mem[1]
        i2c_stop();
        i2c_start();
        send_addr(8'h44, 1'b0);
        set_ptr(8'h07);
        i2c_start();
        send_addr(8'h45, 1'b0);
        rd_data(1'b0);
        rd_data(1'b1);
        i2c_stop();

        // Write a random byte to mem[2] and read it back.
        rnd = 8'($urandom_range(0, 255));
        i2c_start();
        send_addr(8'h44, 1'b0);
        set_ptr(8'h02);
        wr_data(rnd);
        i2c_start();
        send_addr(8'h45, 1'b0);
        ptr_m = 3'd2;  // the pointer moved when the byte was written; read from 2 again
        i2c_stop();
        i2c_start();
        send_addr(8'h44, 1'b0);
        set_ptr(8'h02);
        i2c_start();
        send_addr(8'h45, 1'b0);
        rd_data(1'b1);
        i2c_stop();

        // Test 3: set the pointer, repeated START, then read with ACK then NACK.
        i2c_start();
        send_addr(8'h44, 1'b0);
        set_ptr(8'h03);
        i2c_start();
        send_addr(8'h45, 1'b0);
        check("busy_read", 32'(busy_o), 32'd1);
        rd_data(1'b0);
        rd_data(1'b1);
        check("nack_release", 32'(sda_oe_o), 32'd0);
        i2c_stop();
        wait_clks(Q);
        check("busy_end_read", 32'(busy_o), 32'd0);

        // Test 4: address 0x23 is never acknowledged or driven.
        sda_snap   = sda_oe_cnt;
        pulse_snap = pulse_cnt;
        i2c_start();
        send_addr(8'h46, 1'b1);
        check("busy_other_addr", 32'(busy_o), 32'd0);
        i2c_stop();
        check("other_addr_sda", 32'(sda_oe_cnt - sda_snap), 32'd0);
        check("other_addr_pulse", 32'(pulse_cnt - pulse_snap), 32'd0);

        // Test 5: STOP after 4 data bits; the pointer moves but memory does not.
        i2c_start();
        send_addr(8'h44, 1'b0);
        set_ptr(8'h05);
        for (int i = 0; i < 4; i++) send_bit(1'b1, s);
        i2c_stop();
        wait_clks(Q);
        check("busy_cut", 32'(busy_o), 32'd0);
        i2c_start();
        send_addr(8'h44, 1'b0);
        set_ptr(8'h03);
        i2c_start();
        send_addr(8'h45, 1'b0);
        rd_data(1'b0);
        rd_data(1'b0);
        rd_data(1'b1);  // mem[5] is still untouched
        i2c_stop();
        test1_write();

        // Test 6: reset in the middle of a read byte.
        i2c_start();
        send_addr(8'h44, 1'b0);
        set_ptr(8'h03);
        i2c_start();
        send_addr(8'h45, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, s);
        check("mid_read_drive", 32'(sda_oe_o), 32'd1);  // bit 3 of A5 is 0
        check("mid_read_busy", 32'(busy_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        check("async_rst_sda", 32'(sda_oe_o), 32'd0);
        check("async_rst_busy", 32'(busy_o), 32'd0);
        check("async_rst_valid", 32'(byte_valid_o), 32'd0);
        sda_drv = 1'b1;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(Q);
        model_reset();
        @(negedge clk);
        rst_n_i = 1'b1;
        wait_clks(Q);
        i2c_start();
        send_addr(8'h44, 1'b0);
        set_ptr(8'h03);
        i2c_start();
        send_addr(8'h45, 1'b0);
        rd_data(1'b0);
        rd_data(1'b1);
        i2c_stop();
        wait_clks(2 * Q);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
`ifndef I2C_CLK_STRETCH_EN
        check("scl_oe_idle", 32'(scl_oe_cnt), 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
